mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the execute stage, sitting directly downstream of the instruction decoder. It consumes the decoded M-extension ALU operations (MUL, MULH, DIV, DIVU, REM, REMU) with the two register operands and returns a 32-bit result after a fixed latency. While it works, `busy` stalls the pipeline. A single radix-2 datapath serves all operations: shift-add for multiply, restoring division for divide/remainder.

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between the execute-stage issue logic and mul_div_unit.
// The issuing stage is the master; the arithmetic unit is the slave.
`timescale 1ns/1ps
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, operand_a, operand_b,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the M-extension: shift-add multiply and
// restoring divide share one accumulator, every operation takes the same fixed latency.
`timescale 1ns/1ps
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL6, OP_ILL7
  } op_t;

  state_t          state;
  op_t             op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;   // multiplier shifter / quotient shifter
  logic [XLEN-1:0] opnd;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] a_raw;    // unmodified dividend, returned by REM on divide-by-zero
  logic            neg_res;
  logic            div0;
  logic            ovf;
  logic            is_mul;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  // Start-time decode of the incoming request.
  op_t             op_in;
  logic            signed_in, sa, sb, mul_in, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    op_in     = op_t'(bus.op);
    signed_in = op_in inside {OP_MULH, OP_DIV, OP_REM};
    sa        = signed_in & bus.operand_a[XLEN-1];
    sb        = signed_in & bus.operand_b[XLEN-1];
    a_mag     = sa ? -bus.operand_a : bus.operand_a;
    b_mag     = sb ? -bus.operand_b : bus.operand_b;
    mul_in    = op_in inside {OP_MUL, OP_MULH};
    neg_in    = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV: neg_in = sa ^ sb;
      OP_REM:          neg_in = sa;
      default:         neg_in = 1'b0;
    endcase
  end

  // One radix-2 step; the step taken on the last CALC edge also feeds the result.
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [XLEN-1:0] hi_nx, lo_nx;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh  = {acc_hi, acc_lo[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opnd};
    if (is_mul) begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else begin
      // After a successful subtract the remainder is below the divisor, so it fits XLEN bits.
      hi_nx = div_ge ? XLEN'(div_sh - {1'b0, opnd}) : div_sh[XLEN-1:0];
      lo_nx = {acc_lo[XLEN-2:0], div_ge};
    end
  end

  // Sign fix and special-case overrides for the value written on entry to FINISH.
  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin;

  always_comb begin
    product  = {hi_nx, lo_nx};
    prod_fix = neg_res ? -product : product;
    quo_fix  = neg_res ? -lo_nx : lo_nx;
    rem_fix  = neg_res ? -hi_nx : hi_nx;
    fin      = '0;
    case (op_q)
      OP_MUL:  fin = lo_nx;
      OP_MULH: fin = XLEN'(prod_fix >> XLEN);
      OP_DIV:  fin = div0 ? '1 : (ovf ? INT_MIN : quo_fix);
      OP_DIVU: fin = div0 ? '1 : lo_nx;
      OP_REM:  fin = div0 ? a_raw : (ovf ? '0 : rem_fix);
      OP_REMU: fin = div0 ? a_raw : hi_nx;
      default: fin = '0;
    endcase
  end

  // NOTE: all state, including the datapath registers, uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so a post-reset snapshot is fully defined.
      state    <= IDLE;
      op_q     <= OP_MUL;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      neg_res  <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      is_mul   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (bus.kill) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= op_in;
            a_raw   <= bus.operand_a;
            opnd    <= mul_in ? a_mag : b_mag;
            acc_lo  <= mul_in ? b_mag : a_mag;
            acc_hi  <= '0;
            is_mul  <= mul_in;
            neg_res <= neg_in;
            div0    <= (bus.operand_b == '0);
            ovf     <= signed_in && (bus.operand_a == INT_MIN) && (bus.operand_b == '1);
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            result_q <= fin;
            done_q   <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors pinned to hand-computed values,
// randomized ops, flush and async-reset cases, all compared against an arithmetic model.
`timescale 1ns/1ps
module tb_mul_div_unit;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(XLEN)) bus ();
  mul_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of an M-extension op, straight from the ISA arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return 32'(ua * ub);
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return 32'(sa / sb);
      3'd3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd4: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            else return 32'(sa % sb);
      3'd5: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Cycle-level model: m_cnt counts edges since the accepting edge (0 = idle).
  int          m_cnt;
  logic        m_done;
  logic [31:0] m_result, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_result <= '0; m_pend <= '0;
    end else if (bus.kill) begin
      m_cnt <= 0; m_done <= 1'b0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_cnt  <= 1;
        m_pend <= ref_result(bus.op, bus.operand_a, bus.operand_b);
      end
    end else if (m_cnt == 32) begin
      m_cnt <= 33; m_done <= 1'b1; m_result <= m_pend;
    end else if (m_cnt == 33) begin
      m_cnt <= 0; m_done <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(bus.busy), 32'(m_cnt != 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("result", bus.result, m_result);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit chk_drop);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " value"}, bus.result, exp);
    if (chk_drop) begin
      @(negedge clk);
      check({name, " busy drop"}, 32'(bus.busy), 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] last_exp;
  int          lat;

  initial begin
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    vecs.push_back('{"MUL 7*-3",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{"MULH min*min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{"MULH -1*2",      3'd1, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{"DIV -7/2",       3'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{"REM -7%2",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{"DIVU 100/7",     3'd3, 32'd100,        32'd7,         32'd14});
    vecs.push_back('{"REMU 100%7",     3'd5, 32'd100,        32'd7,         32'd2});
    vecs.push_back('{"DIVU 5/0",       3'd3, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"REMU 5%0",       3'd5, 32'd5,          32'd0,         32'd5});
    vecs.push_back('{"DIV ovf",        3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"REM ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{"illegal op 6",   3'd6, 32'd9,          32'd3,         32'd0});
    vecs.push_back('{"DIV 7/0",        3'd2, 32'd7,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"REM -7%0",       3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});

    foreach (vecs[i]) begin
      check({vecs[i].name, " model"}, ref_result(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    end
    last_exp = vecs[vecs.size()-1].exp;

    // Flush at iteration 10 while start is held high throughout.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'd1234; bus.operand_b = 32'd5678;
    repeat (11) @(negedge clk);
    bus.kill = 1'b1; bus.op = 3'd3; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill busy", 32'(bus.busy), 32'd0);
    check("kill done", 32'(bus.done), 32'd0);
    check("kill result", bus.result, last_exp);
    @(negedge clk);
    bus.start = 1'b0;
    check("held start accepted", 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("post-kill latency", 32'(lat), 32'd33);
    check("post-kill value", bus.result, 32'd14);
    @(negedge clk);

    // Random ops, issued back-to-back at the first idle edge.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, ref_result(op, a, b), 1'b0);
    end

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'($urandom()); bus.operand_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset done", 32'(bus.done), 32'd0);
    check("async reset result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
